// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: tracks hsync/vsync against the expected
// line/frame geometry, recovers pixel coordinates and reports lock and timing errors.
module vga_sync_decoder #(
  parameter int H_DISP     = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_DISP     = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int LOCK_LINES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       pixel_valid,
  output logic [7:0] rgb_out,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FALL = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_RISE = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_FALL = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_RISE = 10'(V_DISP + V_FP + V_SYNC);
  localparam logic [9:0] H_ACT   = 10'(H_DISP);
  localparam logic [9:0] V_ACT   = 10'(V_DISP);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_LINES);

  typedef enum logic [1:0] {SEARCH, H_ACQ, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0] good_q, good_d;
  logic       hs_prev_q, vs_prev_q;
  logic [7:0] rgb_q, errc_q;
  logic       pv_q, fs_q, herr_q, verr_q;
  logic       pv_d, fs_d, herr_d, verr_d;
  logic [9:0] h_adv, v_adv;
  logic       hs_fall, hs_rise, vs_fall, vs_rise, line_start;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    h_adv = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
    v_adv = vcnt_q;
    if (hcnt_q == H_LAST) v_adv = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    hs_fall    = hs_prev_q & ~hsync_in;
    hs_rise    = ~hs_prev_q & hsync_in;
    vs_fall    = vs_prev_q & ~vsync_in;
    vs_rise    = ~vs_prev_q & vsync_in;
    line_start = (h_adv == 10'd0);

    state_d = state_q;
    hcnt_d  = h_adv;
    vcnt_d  = v_adv;
    good_d  = good_q;
    herr_d  = 1'b0;
    verr_d  = 1'b0;

    case (state_q)
      SEARCH: begin
        if (hs_fall) begin
          state_d = H_ACQ;
          hcnt_d  = HS_FALL;
          vcnt_d  = vcnt_q;
          good_d  = 8'd1;
        end
      end
      H_ACQ: begin
        // A resync overrides the line wrap, so the row is left untouched.
        if (hs_fall && h_adv != HS_FALL) begin
          hcnt_d = HS_FALL;
          vcnt_d = vcnt_q;
          good_d = 8'd1;
        end else begin
          if (hs_fall && good_q < LOCK_N) good_d = good_q + 8'd1;
          if (vs_fall && good_q >= LOCK_N) begin
            state_d = LOCKED;
            vcnt_d  = VS_FALL;
          end
        end
      end
      LOCKED: begin
        herr_d = (hs_fall && h_adv != HS_FALL) || (hs_rise && h_adv != HS_RISE) ||
                 (h_adv == HS_FALL && !hs_fall);
        verr_d = (vs_fall && !(line_start && v_adv == VS_FALL)) ||
                 (vs_rise && !(line_start && v_adv == VS_RISE)) ||
                 (line_start && v_adv == VS_FALL && !vs_fall) ||
                 (line_start && v_adv == VS_RISE && !vs_rise);
        if (herr_d || verr_d) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    pv_d = (state_d == LOCKED) && (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    fs_d = (state_d == LOCKED) && (hcnt_d == 10'd0) && (vcnt_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      good_q    <= '0;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
      errc_q    <= '0;
      pv_q      <= 1'b0;
      fs_q      <= 1'b0;
      herr_q    <= 1'b0;
      verr_q    <= 1'b0;
    end else begin
      pv_q   <= 1'b0;
      fs_q   <= 1'b0;
      herr_q <= 1'b0;
      verr_q <= 1'b0;
      if (p_tick) begin
        state_q   <= state_d;
        hcnt_q    <= hcnt_d;
        vcnt_q    <= vcnt_d;
        good_q    <= good_d;
        hs_prev_q <= hsync_in;
        vs_prev_q <= vsync_in;
        pv_q      <= pv_d;
        fs_q      <= fs_d;
        herr_q    <= herr_d;
        verr_q    <= verr_d;
        if (pv_d) rgb_q <= rgb_in;
        if (herr_d || verr_d) errc_q <= sat_inc8(errc_q);
      end
    end
  end

  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign locked      = (state_q == LOCKED);
  assign video_on    = locked && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign pixel_valid = pv_q;
  assign rgb_out     = rgb_q;
  assign frame_start = fs_q;
  assign h_err       = herr_q;
  assign v_err       = verr_q;
  assign err_count   = errc_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced raster: a timing generator drives the
// DUT and a sample-level reference model predicts every output after each tick.
module tb_vga_sync_decoder;

  localparam int HD = 16, HFP = 4, HSW = 6, HBP = 6;
  localparam int VD = 10, VFP = 3, VSW = 2, VBP = 4, LK = 2;
  localparam int HT = HD + HFP + HSW + HBP;
  localparam int VT = VD + VFP + VSW + VBP;
  localparam int HF = HD + HFP, HR = HF + HSW;
  localparam int VF = VD + VFP, VR = VF + VSW;
  localparam int M_SRCH = 0, M_ACQ = 1, M_LCK = 2;

  logic       clk = 1'b0;
  logic       reset, p_tick, hsync_in, vsync_in;
  logic [7:0] rgb_in;
  logic [9:0] x, y;
  logic       video_on, pixel_valid, frame_start, locked, h_err, v_err;
  logic [7:0] rgb_out, err_count;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_DISP(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .LOCK_LINES(LK)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .rgb_in(rgb_in), .x(x), .y(y), .video_on(video_on),
    .pixel_valid(pixel_valid), .rgb_out(rgb_out), .frame_start(frame_start),
    .locked(locked), .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  int    n_chk = 0, n_pass = 0;
  int    per = 4;
  int    n_pv, n_fs, n_he, n_ve;
  string phase = "reset";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: decoder state expressed as mode + predicted raster position.
  int         m_mode, m_col, m_row, m_good, m_ec;
  bit         m_phs, m_pvs, e_pv, e_fs, e_he, e_ve;
  logic [7:0] m_rgb;

  task automatic model_reset();
    m_mode = M_SRCH; m_col = 0; m_row = 0; m_good = 0; m_ec = 0;
    m_phs = 1'b1; m_pvs = 1'b1; m_rgb = 8'd0;
    e_pv = 1'b0; e_fs = 1'b0; e_he = 1'b0; e_ve = 1'b0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [7:0] rgb);
    int col, row;
    bit hf, hr, vf, vr, he, ve, lk;
    col = (m_col + 1) % HT;
    row = (m_col == HT - 1) ? (m_row + 1) % VT : m_row;
    hf = m_phs && !hs; hr = !m_phs && hs;
    vf = m_pvs && !vs; vr = !m_pvs && vs;
    he = 1'b0; ve = 1'b0;
    if (m_mode == M_SRCH) begin
      if (hf) begin col = HF; row = m_row; m_good = 1; m_mode = M_ACQ; end
    end else if (m_mode == M_ACQ) begin
      if (hf && col != HF) begin
        col = HF; row = m_row; m_good = 1;
      end else begin
        if (vf && m_good >= LK) begin row = VF; m_mode = M_LCK; end
        if (hf) m_good = (m_good + 1 > LK) ? LK : m_good + 1;
      end
    end else begin
      // Observed edges must equal the edges the raster position calls for.
      he = (hf != (col == HF)) || (hr && col != HR);
      ve = (vf != (col == 0 && row == VF)) || (vr != (col == 0 && row == VR));
      if (he || ve) m_mode = M_SRCH;
    end
    m_phs = hs; m_pvs = vs; m_col = col; m_row = row;
    lk   = (m_mode == M_LCK);
    e_pv = lk && col < HD && row < VD;
    e_fs = lk && col == 0 && row == 0;
    e_he = he; e_ve = ve;
    if (e_pv) m_rgb = rgb;
    if (he || ve) m_ec = (m_ec + 1 > 255) ? 255 : m_ec + 1;
  endtask

  function automatic logic [63:0] dut_vec();
    return {22'd0, x, y, video_on, pixel_valid, rgb_out, frame_start, locked,
            h_err, v_err, err_count};
  endfunction

  function automatic logic [63:0] exp_vec();
    logic lk, von;
    lk  = (m_mode == M_LCK);
    von = lk && m_col < HD && m_row < VD;
    return {22'd0, 10'(m_col), 10'(m_row), von, e_pv, m_rgb, e_fs, lk, e_he, e_ve, 8'(m_ec)};
  endfunction

  task automatic tick(input bit hs, input bit vs, input logic [7:0] rgb);
    hsync_in = hs; vsync_in = vs; rgb_in = rgb; p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    model_step(hs, vs, rgb);
    chk({phase, "/tick"}, dut_vec(), exp_vec());
    n_pv += int'(pixel_valid); n_fs += int'(frame_start);
    n_he += int'(h_err);       n_ve += int'(v_err);
    e_pv = 1'b0; e_fs = 1'b0; e_he = 1'b0; e_ve = 1'b0;
    for (int i = 1; i < per; i++) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); rgb_in = 8'($urandom);
      @(posedge clk); #1;
      if (i == 1) chk({phase, "/hold"}, dut_vec(), exp_vec());
    end
  endtask

  task automatic clr_counts();
    n_pv = 0; n_fs = 0; n_he = 0; n_ve = 0;
  endtask

  // Raster generator with optional single-line/single-frame sync faults.
  int gh = 0, gv = 0, inj_h_row = -1;
  bit inj_v = 1'b0;

  task automatic gen_tick();
    bit hs, vs;
    hs = !(gh >= HF && gh < HR);
    vs = !(gv >= VF && gv < VR);
    if (gv == inj_h_row && gh == HF) hs = 1'b1;
    if (inj_v && gv == VF - 1) vs = 1'b0;
    tick(hs, vs, 8'($urandom));
    gh++;
    if (gh == HT) begin
      gh = 0;
      if (gv == inj_h_row) inj_h_row = -1;
      if (gv == VF - 1) inj_v = 1'b0;
      gv = (gv + 1) % VT;
    end
  endtask

  task automatic gen_to(input int h, input int v);
    for (int i = 0; i < HT * VT + 1 && !(gh == h && gv == v); i++) gen_tick();
  endtask

  task automatic pulse_reset(input string tag);
    p_tick = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk(tag, dut_vec(), 64'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_pulse;
    reset = 1'b1; p_tick = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", dut_vec(), 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    reset = 1'b0;

    phase = "nominal"; clr_counts();
    gen_to(1, VF);
    chk("nom_locked", {63'd0, locked}, 64'd1);
    gen_to(0, 0); clr_counts();
    repeat (HT * VT) gen_tick();
    chk("nom_pixels", 64'(n_pv), 64'(HD * VD));
    chk("nom_frame_start", 64'(n_fs), 64'd1);
    chk("nom_err_count", {56'd0, err_count}, 64'd0);

    phase = "hshift"; clr_counts(); inj_h_row = 4;
    gen_to(0, 5);
    chk("hshift_herr", 64'(n_he), 64'd1);
    chk("hshift_unlocked", {63'd0, locked}, 64'd0);
    chk("hshift_err_count", {56'd0, err_count}, 64'd1);
    gen_to(1, VF);
    chk("hshift_relock", {63'd0, locked}, 64'd1);

    phase = "vearly"; gen_to(0, 0); clr_counts(); inj_v = 1'b1;
    gen_to(1, VF - 1);
    chk("vearly_verr", 64'(n_ve), 64'd1);
    chk("vearly_unlocked", {63'd0, locked}, 64'd0);
    chk("vearly_err_count", {56'd0, err_count}, 64'd2);
    gen_to(0, 0); gen_to(1, VF);
    chk("vearly_relock", {63'd0, locked}, 64'd1);

    phase = "noise"; pulse_reset("noise_rst"); clr_counts();
    for (int i = 0; i < 200; i++)
      tick(1'((i % 2) ^ int'($urandom_range(0, 7) == 0)), 1'($urandom), 8'($urandom));
    chk("noise_errors", 64'(n_he + n_ve), 64'd0);
    chk("noise_unlocked", {63'd0, locked}, 64'd0);
    gh = 0; gv = 0;
    gen_to(1, VF);
    chk("noise_lock", {63'd0, locked}, 64'd1);

    phase = "midreset"; gen_to(5, 6);
    pulse_reset("midreset_zero");
    gen_to(0, 0); gen_to(1, VF);
    chk("midreset_relock", {63'd0, locked}, 64'd1);

    phase = "freeze"; gen_to(8, 3); clr_counts();
    p_tick = 1'b0; any_pulse = 1'b0;
    repeat (1000) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); rgb_in = 8'($urandom);
      @(posedge clk); #1;
      any_pulse = any_pulse | pixel_valid | frame_start | h_err | v_err;
    end
    chk("freeze_x", {54'd0, x}, 64'(m_col));
    chk("freeze_y", {54'd0, y}, 64'(m_row));
    chk("freeze_rgb", {56'd0, rgb_out}, {56'd0, m_rgb});
    chk("freeze_locked", {63'd0, locked}, 64'd1);
    chk("freeze_pulses", {63'd0, any_pulse}, 64'd0);
    repeat (HT) gen_tick();
    chk("freeze_resume_locked", {63'd0, locked}, 64'd1);
    chk("freeze_resume_errors", 64'(n_he + n_ve), 64'd0);

    phase = "saturate"; pulse_reset("sat_rst"); per = 1;
    for (int it = 0; it < 300; it++) begin
      tick(1'b0, 1'b1, 8'($urandom));
      for (int k = 1; k < HT; k++) tick(1'b1, 1'b1, 8'($urandom));
      tick(1'b0, 1'b1, 8'($urandom));
      tick(1'b1, 1'b0, 8'($urandom));
      tick(1'b0, 1'b0, 8'($urandom));
      tick(1'b1, 1'b1, 8'($urandom));
      if (it == 99) chk("sat_mid", {56'd0, err_count}, 64'd100);
    end
    chk("sat_err_count", {56'd0, err_count}, 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart to the VGA timing generator: samples hsync/vsync/rgb on each pixel tick and recovers pixel coordinates, active-video and frame boundaries.
- Verifies the incoming stream against 640x480 timing and reports lock state and timing errors.
- Sits on the VGA output path (loopback or monitor) for self-check of the display pipeline and for capture of rendered pixels.

Parameters:
- H_DISP, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch; H_TOTAL = sum = 800
- V_DISP, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = 525
- LOCK_LINES, 2, consecutive correct hsync falls required before vertical acquisition

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high
- p_tick  in  1  pixel-rate enable (one clk wide, every 4th clk); all sampling is qualified by it
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- rgb_in  in  8  pixel data
- x  out  10  recovered column of the current sample
- y  out  10  recovered row of the current sample
- video_on  out  1  locked and x<H_DISP and y<V_DISP
- pixel_valid  out  1  one-clk pulse: rgb_out/x/y hold an active pixel
- rgb_out  out  8  captured pixel
- frame_start  out  1  one-clk pulse when a locked sample lands at (0,0)
- locked  out  1  FSM in LOCKED
- h_err  out  1  one-clk pulse: hsync edge at wrong column
- v_err  out  1  one-clk pulse: vsync edge at wrong row
- err_count  out  8  saturating count of h_err+v_err since reset

Behaviour:
- Reset: every output 0, hcnt=vcnt=0, FSM SEARCH, previous-sync registers = 1 (idle high).
- Sampling: hsync_in, vsync_in and rgb_in are registered on the clk where p_tick=1. Nothing changes on clks with p_tick=0. Outputs update on the clk after the sampling tick (latency 1 clk).
- Edge detect: a fall is prev=1 and now=0; a rise is prev=0 and now=1. Edges are detected only between consecutive ticks.
- hcnt: increments each tick and wraps at H_TOTAL-1 to 0. On wrap, vcnt increments and wraps at V_TOTAL-1 to 0.
- Expected edges:
  - hsync fall at hcnt==H_DISP+H_FP (656); hsync rise at 752.
  - vsync fall at vcnt==V_DISP+V_FP (490), sampled at hcnt==0 of that line; vsync rise at vcnt==492.
- FSM SEARCH:
  - On hsync fall, force hcnt=656 and go to H_ACQ with good-line count=1.
  - Other edges are ignored; no errors are flagged.
- FSM H_ACQ:
  - An hsync fall at hcnt==656 increments the good-line count.
  - An hsync fall at any other column resyncs hcnt=656 and sets the count to 1; no error pulse.
  - When the count reaches LOCK_LINES and a vsync fall occurs, force vcnt=490 and go to LOCKED.
- FSM LOCKED:
  - locked=1.
  - Any misplaced hsync edge, or any hsync fall missing at 656, pulses h_err and sends the FSM to SEARCH.
  - Any misplaced or missing vsync edge pulses v_err and sends the FSM to SEARCH.
  - Leaving LOCKED clears locked, video_on and pixel_valid on the same output update.
- err_count: +1 per h_err or v_err pulse; +1 only if both pulse together; saturates at 255; cleared only by reset.
- x/y equal hcnt/vcnt in all states, but are meaningful only while locked.
- pixel_valid = tick AND locked AND active region. rgb_out takes rgb_in of the same sample; it holds its value otherwise.
- Simultaneous events:
  - When a resync and a wrap would both apply on one tick, the resync wins.
  - When hsync and vsync errors occur on the same tick, both pulses fire.
- Reset mid-frame: immediate return to the reset state; reacquisition begins on the next hsync fall.
- Counter widths are exactly 10 bits; no intermediate value exceeds 799.

Test Plan:
- Nominal 640x480 stream from reset, p_tick every 4th clk -> locked=1 at the first vsync fall after ≥2 good lines. First frame_start at (0,0) of the following frame. Exactly 307200 pixel_valid pulses per frame; err_count=0.
- Locked stream, one hsync fall shifted to column 657 -> h_err pulse, locked=0, err_count=1. Relock at the next qualifying vsync fall.
- Locked stream, vsync fall at row 489 -> v_err pulse, err_count increments, FSM to SEARCH.
- Random sync noise before the first clean line -> no error pulses and locked stays 0. Lock is achieved after the clean stream starts.
- Assert reset mid-frame at row 200 -> all outputs 0 on the next clk. Normal reacquisition follows.
- p_tick held low for 1000 clks while locked -> x, y, rgb_out and locked frozen; no errors. Stream resumes without loss of lock.
- Force 300 errors -> err_count saturates at 255.
